// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB PWM driver.
package rgb_pkg;

  localparam int CH_W = 8;
  localparam logic [CH_W-1:0] PWM_MAX = 8'd254;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/pwm_channel.sv
// One colour channel: duty/target registers, optional fade stepping
// (RGB_PWM_FADE_EN) and the registered duty compare.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter int FADE_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            sample,
  input  logic [CH_W-1:0] cnt,
  input  logic [CH_W-1:0] level,
  output logic            pwm,
  output logic            differs
);

  if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_step
    $error("pwm_channel: FADE_STEP must be 1..255");
  end

  logic [CH_W-1:0] duty;
  logic [CH_W-1:0] next_duty;

`ifdef RGB_PWM_FADE_EN
  localparam logic [CH_W-1:0] STEP = CH_W'(FADE_STEP);

  logic [CH_W-1:0] target;
  logic [CH_W-1:0] gap_up;
  logic [CH_W-1:0] gap_dn;

  assign gap_up = level - duty;
  assign gap_dn = duty - level;

  // Step is clamped to the remaining gap so duty lands exactly on the target.
  always_comb begin
    next_duty = duty;
    if (duty < level) begin
      next_duty = duty + ((gap_up < STEP) ? gap_up : STEP);
    end else if (duty > level) begin
      next_duty = duty - ((gap_dn < STEP) ? gap_dn : STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
    end else if (!enable || sample) begin
      target <= level;
    end
  end

  assign differs = (duty != target);
`else
  assign next_duty = level;
  assign differs   = 1'b0;
`endif

  // While disabled the duty tracks the colour directly so a restart never fades.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      pwm <= enable & (cnt < duty);
      if (!enable) begin
        duty <= level;
      end else if (sample) begin
        duty <= next_duty;
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for an RGB LED; colours change only on period
// boundaries. Optional fade toward new colours: define RGB_PWM_FADE_EN.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PRESCALE  = 1,
  parameter int FADE_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_end,
  output logic        busy
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("rgb_pwm_driver: PRESCALE must be >= 1");
  end

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]   presc;
  logic [CH_W-1:0] cnt;
  logic            tick;
  logic            sample;
  logic [2:0]      differs;

  assign tick   = (presc == PW'(PRESCALE - 1));
  assign sample = enable & tick & (cnt == PWM_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else if (!enable) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= (cnt == PWM_MAX) ? '0 : cnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_end <= 1'b0;
      busy       <= 1'b0;
    end else begin
      period_end <= sample;
      busy       <= |differs;
    end
  end

  pwm_channel #(.FADE_STEP(FADE_STEP)) u_ch_r (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .cnt(cnt),
    .level(light[R_HI:R_LO]), .pwm(pwm_r), .differs(differs[2])
  );

  pwm_channel #(.FADE_STEP(FADE_STEP)) u_ch_g (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .cnt(cnt),
    .level(light[G_HI:G_LO]), .pwm(pwm_g), .differs(differs[1])
  );

  pwm_channel #(.FADE_STEP(FADE_STEP)) u_ch_b (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .cnt(cnt),
    .level(light[B_HI:B_LO]), .pwm(pwm_b), .differs(differs[0])
  );

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Consumes the 24-bit `light` colour word ({R,G,B}, 8 bits each) produced by the lights selector.
- Drives three PWM outputs for a physical RGB LED.
- New colours are applied only on PWM period boundaries, so the LED never glitches mid-period.
- Sits between the lights selector and the board LED pins. An optional fade ramps the duty cycles toward each new colour.

Parameters:
- PRESCALE, 1: clock cycles per PWM count; legal range ≥1.
- FADE_STEP, 1: duty change per period, per channel, when fading is compiled in; legal range 1..255.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-high.
- enable, input, 1: PWM run enable.
- light, input, 24: colour word; [23:16]=R, [15:8]=G, [7:0]=B.
- pwm_r, output, 1: red PWM, registered.
- pwm_g, output, 1: green PWM, registered.
- pwm_b, output, 1: blue PWM, registered.
- period_end, output, 1: one-clk pulse on the last clock of each PWM period.
- busy, output, 1: high while any channel duty differs from its target.

Behaviour:
- Reset (async, immediate, no clk edge needed):
  - presc=0, cnt=0.
  - duty_r/g/b=0, target_r/g/b=0.
  - pwm_*=0, period_end=0, busy=0.
- Prescaler: presc counts 0..PRESCALE-1; tick when presc==PRESCALE-1. With PRESCALE=1, tick is every clock.
- PWM counter:
  - 8-bit cnt counts 0..254 on tick, then wraps to 0.
  - Period = 255 ticks = 255*PRESCALE clocks.
- Output compare: pwm_x <= enable & (cnt < duty_x), registered, so outputs lag cnt by one clock.
  - duty=0 gives a constant low output.
  - duty=255 gives a constant high output.
  - duty d gives exactly d*PRESCALE high clocks per period.
- period_end <= tick & (cnt==254) & enable.
- Colour sampling:
  - light is sampled only on the cycle where period_end's condition is true: target <= light.
  - Without fade, duty <= light on that same edge.
  - The new colour is visible from the first cycle of the next period.
  - Light changes at any other time are ignored.
- enable=0:
  - presc and cnt are held at 0; pwm_* and period_end are 0.
  - duty and target load light every clock, so restart uses the current colour with no fade.
- enable 0→1: counting starts from cnt=0 on the next clock.
- First period after reset: duty=0, so the outputs are low for one full period. The light value is applied at the first period_end.
- busy: registered; high when (duty_r,duty_g,duty_b) != (target_r,target_g,target_b). Without fade, busy is constant 0.
- Arithmetic: all duty math is 8-bit unsigned with saturation at the target. Duty never overshoots and never wraps.

Optional Feature:
- Macro: RGB_PWM_FADE_EN.
- Defined: at each period_end, each channel steps toward the newly sampled target:
  - duty_x <= duty_x + min(FADE_STEP, target_x - duty_x) if below target;
  - duty_x <= duty_x - min(FADE_STEP, duty_x - target_x) if above target;
  - unchanged if equal.
  - A new light value sampled mid-fade replaces the target; the fade continues from the current duty.
  - busy behaves as described in Behaviour.
- Undefined:
  - duty jumps to light at period_end;
  - busy tied to 0;
  - FADE_STEP unused.

Decomposition:
- Package rgb_pkg:
  - CH_W=8;
  - PWM_MAX=8'd254 (last cnt value);
  - channel slice constants R_HI/R_LO, G_HI/G_LO, B_HI/B_LO;
  - typedef rgb_t, a packed struct {r,g,b} of 8 bits each.
- Sub-module pwm_channel, instantiated three times:
  - holds duty/target, fade step logic and the registered compare;
  - the top level owns presc, cnt, period_end and the busy OR-reduction.

Test Plan (PRESCALE=1 unless stated):
1. rst high for 20 clk with light=FFFFFF, release, enable=1 → pwm_* low for the first 255 clk, period_end pulse at clk 255, then pwm_* constant high.
2. light=0000FF steady over ≥2 periods → pwm_b high 255/255 clk, pwm_r and pwm_g high 0/255 each period.
3. light=804020 → per period: pwm_r 128, pwm_g 64, pwm_b 32 high clocks. With PRESCALE=4: 512, 256, 128 high clocks per 1020-clock period.
4. light changes 804020→0000FF at cnt=100 → the current period keeps 128/64/32; the next period shows 0/0/255; period_end spacing stays 255 clk.
5. RGB_PWM_FADE_EN, FADE_STEP=16, duty=00, light=FF0000 → red duty per period 16, 32, …, 240, 255 (16 periods); busy high throughout, low one clock after reaching 255. Green and blue stay 0.
6. Assert rst asynchronously at cnt=100 → pwm_* and period_end go 0 before the next clk edge. Separately, enable=0 mid-period → pwm_* 0 from the next clk; re-enable → period restarts at cnt=0 using the current light with no fade.
